// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: N_REQ requesters share one sprite ROM port.
// Lock bursts are capped at MAX_LOCK grants; read data is routed back by grant.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   req, lock      per-requester request and burst lock
//   addr_in        packed addresses, slice i*ADDR_W
//   gnt            combinational one-hot-or-zero grant
//   rom_addr       registered ROM address
//   rom_en         registered ROM read enable
//   rom_data       ROM read data, ROM_LAT cycles after rom_en
//   rd_valid       one-hot read-return strobe
//   rd_data        returned data
// Build option: SPRITE_ARB_RR_EN selects round-robin instead of fixed priority.
module sprite_rom_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 8,
  parameter int ROM_LAT  = 1,
  parameter int MAX_LOCK = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        lock,
  input  logic [N_REQ*ADDR_W-1:0] addr_in,
  output logic [N_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]       rom_addr,
  output logic                    rom_en,
  input  logic [DATA_W-1:0]       rom_data,
  output logic [N_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]       rd_data
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_LOCK + 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t           state;
  logic [IW-1:0]    owner;
  logic [CW-1:0]    lock_cnt;
  logic [N_REQ-1:0] pipe [ROM_LAT+1];
  logic             any_gnt;
  logic [IW-1:0]    gnt_idx;

`ifdef SPRITE_ARB_RR_EN
  logic [IW-1:0] ptr;
`endif

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    if (!rst) begin
      if (state == LOCKED) begin
        // A dropped lock grants nobody this cycle.
        if (req[owner] && lock[owner]) begin
          gnt[owner] = 1'b1;
          gnt_idx    = owner;
          any_gnt    = 1'b1;
        end
      end else begin
`ifdef SPRITE_ARB_RR_EN
        for (int k = 0; k < N_REQ; k++) begin
          int j;
          j = int'(ptr) + k;
          if (j >= N_REQ) j = j - N_REQ;
          if (!any_gnt && req[j]) begin
            gnt[j]  = 1'b1;
            gnt_idx = IW'(j);
            any_gnt = 1'b1;
          end
        end
`else
        for (int k = 0; k < N_REQ; k++) begin
          if (!any_gnt && req[k]) begin
            gnt[k]  = 1'b1;
            gnt_idx = IW'(k);
            any_gnt = 1'b1;
          end
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      lock_cnt <= '0;
      rom_en   <= 1'b0;
      rom_addr <= '0;
      for (int s = 0; s <= ROM_LAT; s++)
        pipe[s] <= '0;
`ifdef SPRITE_ARB_RR_EN
      ptr <= '0;
`endif
    end else begin
      rom_en <= any_gnt;
      if (any_gnt)
        rom_addr <= addr_in[int'(gnt_idx)*ADDR_W +: ADDR_W];
      pipe[0] <= gnt;
      for (int s = 1; s <= ROM_LAT; s++)
        pipe[s] <= pipe[s-1];
`ifdef SPRITE_ARB_RR_EN
      // Also covers the forced-release case: owner+1 is next.
      if (any_gnt)
        ptr <= (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
`endif
      unique case (state)
        IDLE: begin
          if (any_gnt && lock[gnt_idx] && MAX_LOCK > 1) begin
            state    <= LOCKED;
            owner    <= gnt_idx;
            lock_cnt <= CW'(1);
          end
        end
        LOCKED: begin
          // Leave on dropped lock or when this grant hits the cap.
          if (!any_gnt || lock_cnt == CW'(MAX_LOCK - 1)) begin
            state    <= IDLE;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rd_valid = pipe[ROM_LAT];
  assign rd_data  = (|rd_valid) ? rom_data : '0;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter: directed vectors for sprite_rom_arbiter.
// ROM model returns addr[7:0]+0x11 with a two-cycle latency.
module tb_sprite_rom_arbiter;

  localparam int N   = 4;
  localparam int AW  = 12;
  localparam int DW  = 8;
  localparam int LAT = 2;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  lock;
  logic [AW-1:0] a0, a1, a2, a3;
  logic [N*AW-1:0] addr_in;
  logic [N-1:0]  gnt;
  logic [AW-1:0] rom_addr;
  logic          rom_en;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] d1;
  logic [N-1:0]  rd_valid;
  logic [DW-1:0] rd_data;

  int n_checks = 0;
  int n_errors = 0;

  assign addr_in = {a3, a2, a1, a0};

  sprite_rom_arbiter #(
    .N_REQ(N), .ADDR_W(AW), .DATA_W(DW),
    .ROM_LAT(LAT), .MAX_LOCK(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req(req), .lock(lock),
    .addr_in(addr_in),
    .gnt(gnt),
    .rom_addr(rom_addr), .rom_en(rom_en),
    .rom_data(rom_data),
    .rd_valid(rd_valid), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    d1       = '0;
    rom_data = '0;
  end

  always @(posedge clk) begin
    d1       <= rom_addr[7:0] + 8'h11;
    rom_data <= d1;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic [N-1:0] r,
                     input logic [N-1:0] l);
    @(negedge clk);
    req  = r;
    lock = l;
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    lock = '0;
    a0 = 12'h010;
    a1 = 12'h121;
    a2 = 12'h3A5;
    a3 = 12'h232;

    // reset state
    cyc(4'b1111, 4'b0000);
    check("rst_gnt", gnt, 4'b0000);
    cyc(4'b1111, 4'b0000);
    check("rst_rom_en", rom_en, 1'b0);
    check("rst_rom_addr", rom_addr, 12'h000);
    check("rst_rd_valid", rd_valid, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    req = '0;

`ifdef SPRITE_ARB_RR_EN
    // round robin rotation with steady requests
    cyc(4'b1111, 4'b0000);
    check("rr_g0", gnt, 4'b0001);
    cyc(4'b1111, 4'b0000);
    check("rr_g1", gnt, 4'b0010);
    cyc(4'b1111, 4'b0000);
    check("rr_g2", gnt, 4'b0100);
    cyc(4'b1111, 4'b0000);
    check("rr_g3", gnt, 4'b1000);
    check("rr_rv0", rd_valid, 4'b0001);
    check("rr_rd0", rd_data, 8'h21);
    cyc(4'b1111, 4'b0000);
    check("rr_g4", gnt, 4'b0001);
    check("rr_rv1", rd_valid, 4'b0010);
    check("rr_rd1", rd_data, 8'h32);
    // lock cap with pointer now at 1
    for (int i = 0; i < 16; i++) begin
      cyc(4'b1010, 4'b0010);
      check("rr_lock", gnt, 4'b0010);
    end
    cyc(4'b1010, 4'b0010);
    check("rr_after_cap", gnt, 4'b1000);
    cyc(4'b1010, 4'b0010);
    check("rr_resume", gnt, 4'b0010);
`else
    // fixed priority starves requester 3
    for (int i = 0; i < 4; i++) begin
      cyc(4'b1010, 4'b0000);
      check("fp_gnt", gnt, 4'b0010);
    end
    check("fp_addr", rom_addr, 12'h121);
`endif
    cyc(4'b0000, 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    cyc(4'b0000, 4'b0000);
    rst = 1'b0;

    // single read from requester 2
    cyc(4'b0100, 4'b0000);
    check("rd_gnt", gnt, 4'b0100);
    cyc(4'b0000, 4'b0000);
    check("rd_gnt_idle", gnt, 4'b0000);
    check("rd_en", rom_en, 1'b1);
    check("rd_addr", rom_addr, 12'h3A5);
    check("rd_rv_t1", rd_valid, 4'b0000);
    cyc(4'b0000, 4'b0000);
    check("rd_en_off", rom_en, 1'b0);
    check("rd_addr_hold", rom_addr, 12'h3A5);
    check("rd_rv_t2", rd_valid, 4'b0000);
    cyc(4'b0000, 4'b0000);
    check("rd_rv_t3", rd_valid, 4'b0100);
    check("rd_data", rd_data, 8'hB6);
    cyc(4'b0000, 4'b0000);
    check("rd_rv_t4", rd_valid, 4'b0000);

    // lock burst capped at 16, waiting requester 0 then served
    cyc(4'b0100, 4'b0100);
    check("lk_first", gnt, 4'b0100);
    for (int i = 0; i < 15; i++) begin
      cyc(4'b0101, 4'b0100);
      check("lk_hold", gnt, 4'b0100);
    end
    cyc(4'b0101, 4'b0100);
    check("lk_release", gnt, 4'b0001);
    cyc(4'b0100, 4'b0100);
    check("lk_relock", gnt, 4'b0100);
    check("lk_addr0", rom_addr, 12'h010);
    cyc(4'b0110, 4'b0000);
    check("lk_drop_gap", gnt, 4'b0000);
    cyc(4'b0110, 4'b0000);
    check("lk_next", gnt, 4'b0010);
    cyc(4'b0000, 4'b0000);
    check("lk_quiet", gnt, 4'b0000);

    // reset mid-burst with reads in flight
    for (int i = 0; i < 3; i++) begin
      cyc(4'b0100, 4'b0100);
      check("mr_burst", gnt, 4'b0100);
    end
    @(negedge clk);
    rst  = 1'b1;
    req  = 4'b0110;
    lock = 4'b0000;
    #1;
    check("mr_rst_gnt", gnt, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mr_en", rom_en, 1'b0);
    check("mr_rv", rd_valid, 4'b0000);
    check("mr_first", gnt, 4'b0010);
    cyc(4'b0000, 4'b0000);
    check("mr_rv2", rd_valid, 4'b0000);
    check("mr_en2", rom_en, 1'b1);
    check("mr_addr", rom_addr, 12'h121);
    cyc(4'b0000, 4'b0000);
    check("mr_rv3", rd_valid, 4'b0000);
    cyc(4'b0000, 4'b0000);
    check("mr_rv4", rd_valid, 4'b0010);
    check("mr_data", rd_data, 8'h32);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
